// File: rtl/aes_pkg.sv
// Shared AES definitions: field polynomial, GF(2^8) helpers, FSM state
// encoding and the 32-bit column word type.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [31:0] aes_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mix_state_t;

    // Multiply by x (i.e. by 2) in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by 3 = x + 1.
    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

endpackage

// File: rtl/aes_mix_col_word.sv
// Combinational forward MixColumns on a single 32-bit column.
// Byte order: col[31:24] is row 0, col[7:0] is row 3.
module aes_mix_col_word
    import aes_pkg::*;
(
    input  aes_word_t col,
    output aes_word_t mixed
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col[31:24];
    assign a1 = col[23:16];
    assign a2 = col[15:8];
    assign a3 = col[7:0];

    // Fixed circulant matrix {2,3,1,1}; all additions are XOR.
    always_comb begin
        mixed[31:24] = xtime(a0) ^ gmul3(a1) ^ a2        ^ a3;
        mixed[23:16] = a0        ^ xtime(a1) ^ gmul3(a2) ^ a3;
        mixed[15:8]  = a0        ^ a1        ^ xtime(a2) ^ gmul3(a3);
        mixed[7:0]   = gmul3(a0) ^ a1        ^ a2        ^ xtime(a3);
    end

endmodule

// File: rtl/aes_mix_col_iter.sv
// Column-serial forward MixColumns: one column per clock, four clocks per
// block, sharing a single column mixer.
//
// Handshake: col_mix_en is a start request that is taken only when busy is
// low at the sampling edge; requests while busy are dropped, not queued. The
// result on out is complete only in the cycle out_valid is high (a one-cycle
// pulse); in between, out shows partially written columns. There is no
// backpressure on the output side.
//
// The FSM state is visible externally as busy (RUN) / !busy (IDLE).
module aes_mix_col_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in,
    input  logic         col_mix_en,
    output logic [127:0] out,
    output logic         out_valid,
    output logic         busy
);

    mix_state_t   state_q, state_d;
    logic [1:0]   cnt_q;
    logic [127:0] work_q;
    logic [127:0] out_q;
    logic         out_valid_q;
    logic         start;
    logic         last;
    aes_word_t    col_sel;
    aes_word_t    col_mixed;

    // Next-state logic: a start is taken only from IDLE, RUN ends after column 3.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (col_mix_en) begin
                    start   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == 2'd3) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the working-register column addressed by the column counter.
    always_comb begin
        col_sel = work_q[127:96];
        case (cnt_q)
            2'd0: col_sel = work_q[127:96];
            2'd1: col_sel = work_q[95:64];
            2'd2: col_sel = work_q[63:32];
            2'd3: col_sel = work_q[31:0];
            default: col_sel = work_q[127:96];
        endcase
    end

    aes_mix_col_word u_mix (
        .col   (col_sel),
        .mixed (col_mixed)
    );

    // State register; reset aborts any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: latch on start, write one mixed column per RUN cycle, pulse valid after the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 2'd0;
            work_q      <= 128'h0;
            out_q       <= 128'h0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= last;
            if (start) begin
                work_q <= in;
                cnt_q  <= 2'd0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 2'd1;
                case (cnt_q)
                    2'd0: out_q[127:96] <= col_mixed;
                    2'd1: out_q[95:64]  <= col_mixed;
                    2'd2: out_q[63:32]  <= col_mixed;
                    2'd3: out_q[31:0]   <= col_mixed;
                    default: out_q[127:96] <= col_mixed;
                endcase
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_aes_mix_col_iter.sv
// Bench for aes_mix_col_iter: known vectors, mid-run corner cases, reset
// abort, back-to-back starts and random blocks against a GF(2^8) model.
module tb_aes_mix_col_iter;

    logic         clk;
    logic         rst;
    logic [127:0] in_data;
    logic         col_mix_en;
    logic [127:0] out_data;
    logic         out_valid;
    logic         busy;

    aes_mix_col_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in_data),
        .col_mix_en (col_mix_en),
        .out        (out_data),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs[3];
    logic [127:0] exp_q[$];
    int           compared   = 0;
    int           mismatched = 0;
    int           mon_cmp    = 0;
    int           mon_err    = 0;
    int           valid_cnt  = 0;
    logic         prev_valid = 1'b0;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] VB_IN    = 128'hdb135345f20a225c010101012d26314c;
    localparam logic [127:0] VB_OUT   = 128'h8e4da1bc9fdc589d010101014d7ebdf8;
    localparam logic [127:0] VC_IN    = 128'hc6c6c6c6d4d4d4d5c6c6c6c6d4d4d4d5;
    localparam logic [127:0] VC_OUT   = 128'hc6c6c6c6d5d5d7d6c6c6c6c6d5d5d7d6;

    // Generic shift-and-add GF(2^8) multiply
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Reference MixColumns over the whole state
    function automatic logic [127:0] mix_model(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   base[4];
        logic [7:0]   a[4];
        logic [7:0]   b;
        base = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gf_mul(base[(j - row + 4) % 4], a[j]);
                r[127 - 32*c - 8*row -: 8] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare every valid pulse against the expected queue
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid) begin
                valid_cnt = valid_cnt + 1;
                mon_cmp = mon_cmp + 1;
                if (prev_valid) begin
                    mon_err = mon_err + 1;
                    $display("FAIL valid_consec: got out_valid high two cycles in a row, expected single pulse");
                end
                mon_cmp = mon_cmp + 1;
                if (exp_q.size() == 0) begin
                    mon_err = mon_err + 1;
                    $display("FAIL unexpected_valid: got out=%h with no expected result queued", out_data);
                end else begin
                    logic [127:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        mon_err = mon_err + 1;
                        $display("FAIL sb_out: got %h expected %h", out_data, e);
                    end
                end
            end
            prev_valid <= out_valid;
        end
    end

    // Drive one start cycle; returns at start edge + 1
    task automatic start_block(input logic [127:0] d, input logic [127:0] e, input bit push);
        in_data    = d;
        col_mix_en = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        col_mix_en = 1'b0;
    endtask

    // One isolated block with latency checks
    task automatic run_block(input logic [127:0] d, input logic [127:0] e, input string name);
        start_block(d, e, 1'b1);
        chk({name, "_busy_k"}, {127'h0, busy}, 128'h1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk({name, "_valid_k3"}, {127'h0, out_valid}, 128'h0);
        chk({name, "_busy_k3"}, {127'h0, busy}, 128'h1);
        @(posedge clk); #1;
        chk({name, "_valid_k4"}, {127'h0, out_valid}, 128'h1);
        chk({name, "_busy_k4"}, {127'h0, busy}, 128'h0);
        chk({name, "_out_k4"}, out_data, e);
        @(posedge clk); #1;
        chk({name, "_valid_k5"}, {127'h0, out_valid}, 128'h0);
        chk({name, "_out_hold"}, out_data, e);
    endtask

    initial begin
        int v0;
        rst        = 1'b1;
        col_mix_en = 1'b0;
        in_data    = 128'h0;

        vecs[0] = '{din: FIPS_IN, exp: FIPS_OUT};
        vecs[1] = '{din: VB_IN,   exp: VB_OUT};
        vecs[2] = '{din: VC_IN,   exp: VC_OUT};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out_data, 128'h0);
        chk("rst_busy", {127'h0, busy}, 128'h0);
        chk("rst_valid", {127'h0, out_valid}, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known vectors
        for (int i = 0; i < 3; i++) begin
            run_block(vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Starts and input changes during RUN are ignored
        v0 = valid_cnt;
        start_block(FIPS_IN, FIPS_OUT, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            in_data    = rand128();
            col_mix_en = 1'b1;
            @(posedge clk); #1;
        end
        col_mix_en = 1'b0;
        in_data    = rand128();
        @(posedge clk); #1;
        chk("ignore_out", out_data, FIPS_OUT);
        chk("ignore_valid", {127'h0, out_valid}, 128'h1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("ignore_pulses", 128'(valid_cnt - v0), 128'd1);

        // Reset in the middle of RUN aborts the block
        start_block(VB_IN, VB_OUT, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_out", out_data, 128'h0);
        chk("abort_busy", {127'h0, busy}, 128'h0);
        chk("abort_valid", {127'h0, out_valid}, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        v0 = valid_cnt;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("abort_no_valid", 128'(valid_cnt - v0), 128'd0);
        run_block(FIPS_IN, FIPS_OUT, "post_abort");

        // Back-to-back: start held high, input alternating
        v0 = valid_cnt;
        for (int i = 0; i < 12; i++) begin
            in_data    = (i % 2 == 0) ? FIPS_IN : VB_IN;
            col_mix_en = 1'b1;
            if (i == 0 || i == 5 || i == 10) exp_q.push_back((i % 2 == 0) ? FIPS_OUT : VB_OUT);
            @(posedge clk); #1;
            chk($sformatf("b2b_valid_%0d", i), {127'h0, out_valid}, (i == 4 || i == 9) ? 128'h1 : 128'h0);
            if (i == 4) chk("b2b_out_4", out_data, FIPS_OUT);
            if (i == 9) chk("b2b_out_9", out_data, VB_OUT);
        end
        col_mix_en = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("b2b_pulses", 128'(valid_cnt - v0), 128'd3);

        // Random blocks with random noise on the inputs during RUN
        for (int n = 0; n < 1000; n++) begin
            logic [127:0] d;
            int gap;
            d = rand128();
            start_block(d, mix_model(d), 1'b1);
            for (int i = 1; i <= 4; i++) begin
                col_mix_en = 1'($urandom_range(0, 1));
                in_data    = rand128();
                @(posedge clk); #1;
            end
            col_mix_en = 1'b0;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end

        // Drain
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'd0);

        compared   = compared + mon_cmp;
        mismatched = mismatched + mon_err;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
